// File: rtl/wb_spi_pkg.sv
// Register map and status bit positions for the Wishbone SPI target.
// The SPI-master driver headers use the same values.
package wb_spi_pkg;

  localparam logic [3:0] REG_STATUS = 4'd0;
  localparam logic [3:0] REG_DATA   = 4'd1;

  localparam int ST_RX_VALID    = 0;
  localparam int ST_TX_FULL     = 1;
  localparam int ST_ENABLE      = 2;
  localparam int ST_RX_OVERRUN  = 3;
  localparam int ST_TX_UNDERRUN = 4;
  localparam int ST_SELECTED    = 5;

  typedef enum logic {
    ENG_IDLE  = 1'b0,
    ENG_SHIFT = 1'b1
  } eng_state_t;

endpackage

// File: rtl/spi_fifo.sv
// Synchronous FIFO with a show-ahead head. A push into a full FIFO is dropped.
// A pop from an empty FIFO is ignored.
module spi_fifo #(
  parameter int width = 8,
  parameter int depth = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [width-1:0]           din,
  output logic [width-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(depth+1)-1:0] count
);
  localparam int aw = (depth > 1) ? $clog2(depth) : 1;
  localparam int cw = $clog2(depth + 1);

  logic [width-1:0] mem [depth];
  logic [aw-1:0]    wr_ptr;
  logic [aw-1:0]    rd_ptr;
  logic [cw-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == cw'(depth));
  assign empty   = (cnt == {cw{1'b0}});
  assign count   = cnt;
  assign dout    = mem[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because depth is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= {aw{1'b0}};
      rd_ptr <= {aw{1'b0}};
      cnt    <= {cw{1'b0}};
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + aw'(1'b1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + aw'(1'b1);
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + cw'(1'b1);
        2'b01:   cnt <= cnt - cw'(1'b1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/wb_spi_slave.sv
// Wishbone SPI target (mode 0, MSB first). An RX FIFO and a TX FIFO sit behind
// the STATUS/CTRL and DATA registers. The SPI pins are synchronized into clk.
module wb_spi_slave
  import wb_spi_pkg::*;
#(
  parameter int d_width    = 8,
  parameter int fifo_depth = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  input  logic        sclk,
  input  logic        ss_n,
  input  logic        mosi_rxd,
  output logic        miso_txd
);
  localparam int cnt_w  = $clog2(d_width + 1);
  localparam int fcnt_w = $clog2(fifo_depth + 1);
  localparam logic [cnt_w-1:0] word_done = cnt_w'(d_width);
  localparam logic [cnt_w-1:0] word_last = cnt_w'(d_width - 1);

  logic [1:0] sclk_sync, ss_sync, mosi_sync;
  logic       sclk_d, ss_d;
  logic       sclk_rise, sclk_fall, ss_rise, ss_fall;

  eng_state_t         state;
  logic [d_width-1:0] tx_sh, rx_sh, rx_word, tx_next;
  logic [cnt_w-1:0]   bit_cnt;
  logic               rx_push, tx_load;

  logic               ack, acc, wr_status, enable, rx_overrun, tx_underrun;
  logic [3:0]         reg_sel;
  logic [31:0]        status, rd_data;

  logic               rx_pop, rx_full, rx_empty;
  logic               tx_push, tx_pop, tx_full, tx_empty;
  logic [d_width-1:0] rx_dout, tx_dout;
  logic [fcnt_w-1:0]  rx_count, tx_count;
  logic               unused_bits;

  assign unused_bits = ^{wb_sel_i, wb_adr_i[31:6], wb_adr_i[1:0], wb_dat_i[31:d_width], rx_count, tx_count};

  // Two-flop synchronizers, then registered edge pulses taken from the second flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_sync <= 2'b00;
      ss_sync   <= 2'b11;
      mosi_sync <= 2'b00;
      sclk_d    <= 1'b0;
      ss_d      <= 1'b1;
      sclk_rise <= 1'b0;
      sclk_fall <= 1'b0;
      ss_rise   <= 1'b0;
      ss_fall   <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[0], sclk};
      ss_sync   <= {ss_sync[0], ss_n};
      mosi_sync <= {mosi_sync[0], mosi_rxd};
      sclk_d    <= sclk_sync[1];
      ss_d      <= ss_sync[1];
      sclk_rise <= sclk_sync[1] & ~sclk_d;
      sclk_fall <= ~sclk_sync[1] & sclk_d;
      ss_rise   <= ss_sync[1] & ~ss_d;
      ss_fall   <= ~ss_sync[1] & ss_d;
    end
  end

  always_comb begin
    tx_load = 1'b0;
    if (state == ENG_IDLE) begin
      tx_load = ss_fall & enable;
    end else begin
      tx_load = enable & ~ss_rise & sclk_fall & (bit_cnt == word_done);
    end
  end

  assign tx_pop   = tx_load & ~tx_empty;
  assign tx_next  = tx_empty ? {d_width{1'b0}} : tx_dout;
  assign miso_txd = tx_sh[d_width-1];

  // Engine: deselect or disable has priority over any sclk edge in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ENG_IDLE;
      tx_sh   <= {d_width{1'b0}};
      rx_sh   <= {d_width{1'b0}};
      rx_word <= {d_width{1'b0}};
      bit_cnt <= {cnt_w{1'b0}};
      rx_push <= 1'b0;
    end else begin
      rx_push <= 1'b0;
      case (state)
        ENG_IDLE: begin
          if (ss_fall && enable) begin
            state   <= ENG_SHIFT;
            tx_sh   <= tx_next;
            bit_cnt <= {cnt_w{1'b0}};
          end
        end
        ENG_SHIFT: begin
          if (ss_rise || !enable) begin
            state   <= ENG_IDLE;
            tx_sh   <= {d_width{1'b0}};
            bit_cnt <= {cnt_w{1'b0}};
          end else if (sclk_rise && (bit_cnt != word_done)) begin
            rx_sh   <= {rx_sh[d_width-2:0], mosi_sync[1]};
            bit_cnt <= bit_cnt + cnt_w'(1'b1);
            if (bit_cnt == word_last) begin
              rx_push <= 1'b1;
              rx_word <= {rx_sh[d_width-2:0], mosi_sync[1]};
            end
          end else if (sclk_fall) begin
            if (bit_cnt == word_done) begin
              tx_sh   <= tx_next;
              bit_cnt <= {cnt_w{1'b0}};
            end else begin
              tx_sh <= {tx_sh[d_width-2:0], 1'b0};
            end
          end
        end
        default: begin
          state <= ENG_IDLE;
          tx_sh <= {d_width{1'b0}};
        end
      endcase
    end
  end

  assign reg_sel   = wb_adr_i[5:2];
  assign acc       = wb_stb_i & wb_cyc_i & ~ack;
  assign wb_ack_o  = wb_stb_i & wb_cyc_i & ack;
  assign wr_status = acc & wb_we_i & (reg_sel == REG_STATUS);

  always_comb begin
    status                 = 32'd0;
    status[ST_RX_VALID]    = ~rx_empty;
    status[ST_TX_FULL]     = tx_full;
    status[ST_ENABLE]      = enable;
    status[ST_RX_OVERRUN]  = rx_overrun;
    status[ST_TX_UNDERRUN] = tx_underrun;
    status[ST_SELECTED]    = ~ss_sync[1];
  end

  // FIFO side effects fire only on the cycle that sets ack.
  always_comb begin
    rd_data = 32'd0;
    rx_pop  = 1'b0;
    tx_push = 1'b0;
    case (reg_sel)
      REG_STATUS: rd_data = status;
      REG_DATA: begin
        if (rx_empty) begin
          rd_data = 32'd0;
        end else begin
          rd_data = {{(32-d_width){1'b0}}, rx_dout};
        end
        rx_pop  = acc & ~wb_we_i;
        tx_push = acc & wb_we_i;
      end
      default: rd_data = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ack         <= 1'b0;
      wb_dat_o    <= 32'd0;
      enable      <= 1'b0;
      rx_overrun  <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      ack      <= acc;
      wb_dat_o <= (acc & ~wb_we_i) ? rd_data : 32'd0;
      if (wr_status) begin
        enable <= wb_dat_i[ST_ENABLE];
      end
      rx_overrun  <= (rx_overrun & ~(wr_status & wb_dat_i[ST_RX_OVERRUN])) | (rx_push & rx_full);
      tx_underrun <= (tx_underrun & ~(wr_status & wb_dat_i[ST_TX_UNDERRUN])) | (tx_load & tx_empty);
    end
  end

  spi_fifo #(.width(d_width), .depth(fifo_depth)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rx_push),
    .pop   (rx_pop),
    .din   (rx_word),
    .dout  (rx_dout),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  spi_fifo #(.width(d_width), .depth(fifo_depth)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_push),
    .pop   (tx_pop),
    .din   (wb_dat_i[d_width-1:0]),
    .dout  (tx_dout),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

endmodule

// File: tb/tb_wb_spi_slave.sv
// Self-checking bench for wb_spi_slave: a bit-banged SPI master and Wishbone CPU tasks.
// A word-level queue model predicts the FIFO contents, the status flags and the MISO bytes.
module tb_wb_spi_slave;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int HALF  = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_stb_i, wb_cyc_i, wb_we_i;
  logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic        wb_ack_o;
  logic        sclk, ss_n, mosi_rxd, miso_txd;

  always #5 clk = ~clk;

  wb_spi_slave #(.d_width(DW), .fifo_depth(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .wb_stb_i (wb_stb_i),
    .wb_cyc_i (wb_cyc_i),
    .wb_we_i  (wb_we_i),
    .wb_adr_i (wb_adr_i),
    .wb_sel_i (wb_sel_i),
    .wb_dat_i (wb_dat_i),
    .wb_dat_o (wb_dat_o),
    .wb_ack_o (wb_ack_o),
    .sclk     (sclk),
    .ss_n     (ss_n),
    .mosi_rxd (mosi_rxd),
    .miso_txd (miso_txd)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] m_tx[$];
  logic [7:0] m_rx[$];
  bit         m_en, m_over, m_under;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [7:0] m_tx_take();
    if (m_tx.size() > 0) return m_tx.pop_front();
    m_under = 1'b1;
    return 8'h00;
  endfunction

  function automatic logic [31:0] m_status(input bit sel);
    return {26'd0, sel, m_under, m_over, m_en, (m_tx.size() == DEPTH), (m_rx.size() != 0)};
  endfunction

  task automatic m_reset();
    m_tx.delete();
    m_rx.delete();
    m_en    = 1'b0;
    m_over  = 1'b0;
    m_under = 1'b0;
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wb_access(input bit we, input logic [31:0] adr, input logic [31:0] wdat, output logic [31:0] rdat);
    bit got;
    got      = 1'b0;
    rdat     = 32'd0;
    wb_adr_i = adr;
    wb_dat_i = wdat;
    wb_we_i  = we;
    wb_stb_i = 1'b1;
    wb_cyc_i = 1'b1;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (wb_ack_o) begin
        got  = 1'b1;
        rdat = wb_dat_o;
      end
    end
    wb_stb_i = 1'b0;
    wb_cyc_i = 1'b0;
    wb_we_i  = 1'b0;
    if (!got) check("wb_ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic cpu_write(input logic [31:0] adr, input logic [31:0] dat);
    logic [31:0] unused_rd;
    wb_access(1'b1, adr, dat, unused_rd);
    if (adr == 32'h0) begin
      m_en = dat[2];
      if (dat[3]) m_over = 1'b0;
      if (dat[4]) m_under = 1'b0;
    end else if (adr == 32'h4) begin
      if (m_tx.size() < DEPTH) m_tx.push_back(dat[7:0]);
    end
  endtask

  task automatic cpu_read_status(input string tag, input bit sel, output logic [31:0] rd);
    wb_access(1'b0, 32'h0, 32'd0, rd);
    check(tag, rd, m_status(sel));
  endtask

  task automatic cpu_read_data(input string tag);
    logic [31:0] rd;
    logic [31:0] exp;
    wb_access(1'b0, 32'h4, 32'd0, rd);
    exp = (m_rx.size() > 0) ? {24'd0, m_rx.pop_front()} : 32'd0;
    check(tag, rd, exp);
  endtask

  // Mode 0: MOSI is set while sclk is low and MISO is sampled at the rising edge.
  // On the last bit of a select, ss_n rises together with the final falling edge.
  task automatic spi_bits(input logic [7:0] mo, input int nbits, input bit last, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi_rxd = mo[7-i];
      wait_clk(HALF);
      mi   = {mi[6:0], miso_txd};
      sclk = 1'b1;
      wait_clk(HALF);
      sclk = 1'b0;
      if (last && i == nbits - 1) ss_n = 1'b1;
    end
  endtask

  task automatic spi_burst(input int nwords, input int pbits, input bit fixed, input logic [7:0] mo0);
    logic [7:0] mo, mi, load;
    bit en;
    bit last;
    en   = m_en;
    ss_n = 1'b0;
    load = en ? m_tx_take() : 8'h00;
    wait_clk(HALF);
    for (int w = 0; w < nwords; w++) begin
      last = (w == nwords - 1) && (pbits == 0);
      mo   = fixed ? mo0 : 8'($urandom);
      spi_bits(mo, 8, last, mi);
      check("spi_miso", {24'd0, mi}, {24'd0, load});
      if (en) begin
        if (m_rx.size() < DEPTH) m_rx.push_back(mo);
        else m_over = 1'b1;
      end
      if (!last) load = en ? m_tx_take() : 8'h00;
    end
    if (pbits > 0) spi_bits(8'($urandom), pbits, 1'b1, mi);
    mosi_rxd = 1'b0;
    wait_clk(2 * HALF);
  endtask

  initial begin
    logic [31:0] rd;
    logic [7:0]  mi;

    reset    = 1'b0;
    wb_stb_i = 1'b0;
    wb_cyc_i = 1'b0;
    wb_we_i  = 1'b0;
    wb_adr_i = 32'd0;
    wb_dat_i = 32'd0;
    wb_sel_i = 4'hF;
    sclk     = 1'b0;
    ss_n     = 1'b1;
    mosi_rxd = 1'b0;
    m_reset();
    wait_clk(3);
    check("rst_dat_o", wb_dat_o, 32'd0);
    check("rst_ack_o", {31'd0, wb_ack_o}, 32'd0);
    check("rst_miso", {31'd0, miso_txd}, 32'd0);
    reset = 1'b1;
    wait_clk(4);
    cpu_read_status("rst_status", 1'b0, rd);
    cpu_read_data("rst_data_empty");

    // Single word in both directions.
    cpu_write(32'h0, 32'h4);
    cpu_write(32'h4, 32'hA5);
    spi_burst(1, 0, 1'b1, 8'h3C);
    cpu_read_status("t1_status", 1'b0, rd);
    check("t1_status_lit", rd, 32'h05);
    cpu_read_data("t1_data");
    cpu_read_status("t1_status_after", 1'b0, rd);
    check("t1_status_after_lit", rd, 32'h04);

    // Three words with only two queued: the third goes out as zero.
    cpu_write(32'h4, 32'h11);
    cpu_write(32'h4, 32'h22);
    spi_burst(3, 0, 1'b0, 8'h00);
    cpu_read_status("t2_status", 1'b0, rd);
    check("t2_underrun", {31'd0, rd[4]}, 32'd1);
    cpu_write(32'h0, 32'h10);
    cpu_read_status("t2_status_clr", 1'b0, rd);
    check("t2_underrun_clr", {31'd0, rd[4]}, 32'd0);
    repeat (3) cpu_read_data("t2_data");

    // Five words into a four-deep RX FIFO.
    cpu_write(32'h0, 32'h4);
    spi_burst(5, 0, 1'b0, 8'h00);
    cpu_read_status("t3_status", 1'b0, rd);
    check("t3_overrun", {31'd0, rd[3]}, 32'd1);
    repeat (5) cpu_read_data("t3_data");
    cpu_write(32'h0, 32'h1C);
    cpu_read_status("t3_status_clr", 1'b0, rd);

    // A partial word is discarded, then a full word is received.
    spi_burst(0, 5, 1'b0, 8'h00);
    cpu_read_status("t4_status", 1'b0, rd);
    check("t4_rx_valid", {31'd0, rd[0]}, 32'd0);
    spi_burst(1, 0, 1'b0, 8'h00);
    cpu_read_data("t4_data");

    // Disabled engine: MISO stays low and nothing is received.
    cpu_write(32'h4, 32'h77);
    cpu_write(32'h0, 32'h0);
    ss_n = 1'b0;
    wait_clk(4);
    cpu_read_status("t5_selected", 1'b1, rd);
    ss_n = 1'b1;
    wait_clk(2 * HALF);
    spi_burst(1, 0, 1'b1, 8'hFF);
    cpu_read_status("t5_status", 1'b0, rd);
    check("t5_rx_valid", {31'd0, rd[0]}, 32'd0);

    // Reset in the middle of a word.
    cpu_write(32'h0, 32'h4);
    cpu_write(32'h4, 32'h5A);
    ss_n = 1'b0;
    wait_clk(HALF);
    spi_bits(8'hC3, 4, 1'b0, mi);
    reset = 1'b0;
    wait_clk(1);
    check("t6_rst_dat_o", wb_dat_o, 32'd0);
    check("t6_rst_miso", {31'd0, miso_txd}, 32'd0);
    wait_clk(2);
    reset = 1'b1;
    m_reset();
    spi_bits(8'h3C, 4, 1'b1, mi);
    check("t6_miso_after_rst", {24'd0, mi}, 32'd0);
    mosi_rxd = 1'b0;
    wait_clk(2 * HALF);
    cpu_read_status("t6_status", 1'b0, rd);
    check("t6_status_lit", rd, 32'h00);
    cpu_write(32'h0, 32'h4);
    cpu_write(32'h4, 32'h96);
    spi_burst(1, 0, 1'b1, 8'h69);
    cpu_read_data("t6_data");

    // Random mix of CPU and SPI traffic against the queue model.
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: repeat ($urandom_range(1, 3)) cpu_write(32'h4, $urandom);
        3, 4, 5: spi_burst($urandom_range(1, 3), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0, 1'b0, 8'h00);
        6, 7: repeat ($urandom_range(1, 2)) cpu_read_data("rnd_data");
        8: cpu_read_status("rnd_status", 1'b0, rd);
        default: cpu_write(32'h0, {27'd0, 1'($urandom), 1'($urandom), ($urandom_range(0, 4) != 0), 2'b00});
      endcase
    end
    cpu_read_status("final_status", 1'b0, rd);
    while (m_rx.size() > 0) cpu_read_data("final_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
